// File: rtl/keypad_pkg.sv
// Shared types, key code constants and the 4x4 keypad map.
package keypad_pkg;

   typedef enum logic [2:0] {IDLE, DEBOUNCE, COMMIT, HELD, RELEASE} ctrl_state_t;

   localparam logic [3:0] KEY_A = 4'hA;
   localparam logic [3:0] KEY_B = 4'hB;
   localparam logic [3:0] KEY_C = 4'hC;
   localparam logic [3:0] KEY_D = 4'hD;
   localparam logic [3:0] KEY_E = 4'hE;
   localparam logic [3:0] KEY_F = 4'hF;

   // Rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0:    k = 4'h1;
         4'h1:    k = 4'h2;
         4'h2:    k = 4'h3;
         4'h3:    k = KEY_A;
         4'h4:    k = 4'h4;
         4'h5:    k = 4'h5;
         4'h6:    k = 4'h6;
         4'h7:    k = KEY_B;
         4'h8:    k = 4'h7;
         4'h9:    k = 4'h8;
         4'hA:    k = 4'h9;
         4'hB:    k = KEY_C;
         4'hC:    k = KEY_E;
         4'hD:    k = 4'h0;
         4'hE:    k = KEY_F;
         default: k = KEY_D;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/keypad_key_decoder.sv
// Combinational row/column to hex key code decoder; valid only when both are one-hot.
module keypad_key_decoder
   import keypad_pkg::*;
(
   input  logic [3:0] row,
   input  logic [3:0] col,
   output logic [3:0] code,
   output logic       one_hot_valid
);

   function automatic logic is_one_hot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] enc(input logic [3:0] v);
      logic [1:0] i;
      case (v)
         4'b0010: i = 2'd1;
         4'b0100: i = 2'd2;
         4'b1000: i = 2'd3;
         default: i = 2'd0;
      endcase
      return i;
   endfunction

   always_comb begin
      one_hot_valid = is_one_hot(row) && is_one_hot(col);
      code          = key_map(enc(row), enc(col));
   end

endmodule

// File: rtl/keypad_key_controller.sv
// Debounces scanner hits into one-shot key events and keeps a two-digit history.
//   state    | meaning
//   IDLE     | waiting for a decoded hit
//   DEBOUNCE | counting stable cycles of the candidate key
//   COMMIT   | one cycle: key_valid pulse, history shifted
//   HELD     | key down, further presses ignored
//   RELEASE  | counting released cycles before re-arming
module keypad_key_controller
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 240_000,
   parameter int RELEASE_CYCLES  = 240_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   input  logic [3:0] col,
   input  logic       en,
   output logic [3:0] digit_new,
   output logic [3:0] digit_old,
   output logic       key_valid,
   output logic       key_held
);

   localparam int MAXC = (DEBOUNCE_CYCLES > RELEASE_CYCLES) ? DEBOUNCE_CYCLES : RELEASE_CYCLES;
   localparam int CW   = $clog2(MAXC) + 1;
   localparam logic [CW-1:0] DEB_TC = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] REL_TC = CW'(RELEASE_CYCLES - 1);

   ctrl_state_t   state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
   logic [3:0]    cand_key, cand_nxt, dnew_nxt, dold_nxt;
   logic [3:0]    code;
   logic          one_hot_valid, hit;

   keypad_key_decoder u_dec (
      .row           (row),
      .col           (col),
      .code          (code),
      .one_hot_valid (one_hot_valid)
   );

   assign hit     = en && one_hot_valid;
   assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         cand_key  <= 4'd0;
         digit_new <= 4'd0;
         digit_old <= 4'd0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         cand_key  <= cand_nxt;
         digit_new <= dnew_nxt;
         digit_old <= dold_nxt;
      end
   end

   // History shifts on entry to COMMIT so digit_new changes with the key_valid pulse.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cand_nxt  = cand_key;
      dnew_nxt  = digit_new;
      dold_nxt  = digit_old;
      case (state)
         IDLE: begin
            if (hit) begin
               cand_nxt  = code;
               cnt_nxt   = '0;
               state_nxt = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (hit && (code == cand_key)) begin
               if (cnt == DEB_TC) begin
                  state_nxt = COMMIT;
                  dnew_nxt  = cand_key;
                  dold_nxt  = digit_new;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         COMMIT: state_nxt = HELD;
         HELD: begin
            if (!en) begin
               cnt_nxt   = '0;
               state_nxt = RELEASE;
            end
         end
         RELEASE: begin
            if (en)                  state_nxt = HELD;
            else if (cnt == REL_TC)  state_nxt = IDLE;
            else                     cnt_nxt   = cnt_inc;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign key_valid = (state == COMMIT);
   assign key_held  = (state == DEBOUNCE) || (state == COMMIT) ||
                      (state == HELD)     || (state == RELEASE);

endmodule

// File: tb/tb_keypad_key_controller.sv
// Directed plus randomized bench for keypad_key_controller with a run-length reference model.
module tb_keypad_key_controller;

   localparam int D = 8;
   localparam int R = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] row = 4'd0;
   logic [3:0] col = 4'd0;
   logic       en = 1'b0;
   logic [3:0] digit_new, digit_old;
   logic       key_valid, key_held;

   int tests = 0;
   int fails = 0;
   int pulses = 0;

   // Model: armed/disarmed, length of the current stable press run, length of the low-en run.
   int         m_run, m_low;
   bit         m_pend, m_armed;
   logic [3:0] m_cand, m_new, m_old;

   logic [3:0] layout [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                 '{4'h4, 4'h5, 4'h6, 4'hB},
                                 '{4'h7, 4'h8, 4'h9, 4'hC},
                                 '{4'hE, 4'h0, 4'hF, 4'hD}};

   keypad_key_controller #(.DEBOUNCE_CYCLES(D), .RELEASE_CYCLES(R)) dut (
      .clk       (clk),
      .reset     (reset),
      .row       (row),
      .col       (col),
      .en        (en),
      .digit_new (digit_new),
      .digit_old (digit_old),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int idx(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_run = 0; m_low = 0; m_pend = 0; m_armed = 1;
      m_cand = 4'd0; m_new = 4'd0; m_old = 4'd0;
   endtask

   task automatic model_edge();
      bit         hit;
      logic [3:0] code;
      hit  = en && ($countones(row) == 1) && ($countones(col) == 1);
      code = hit ? layout[idx(row)][idx(col)] : 4'd0;
      if (m_pend) begin
         m_pend = 0; m_armed = 0; m_low = 0;
      end else if (!m_armed) begin
         m_low = en ? 0 : m_low + 1;
         // One low cycle leaves HELD, then R more in RELEASE.
         if (m_low == R + 1) begin m_armed = 1; m_run = 0; end
      end else if (hit && (m_run == 0 || code == m_cand)) begin
         if (m_run == 0) m_cand = code;
         m_run++;
         if (m_run == D + 1) begin
            m_pend = 1; m_old = m_new; m_new = m_cand; m_run = 0;
         end
      end else begin
         m_run = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("key_valid", key_valid, m_pend);
      chk("key_held", key_held, (m_pend || !m_armed || m_run > 0));
      chk("digit_new", digit_new, m_new);
      chk("digit_old", digit_old, m_old);
      if (key_valid) pulses++;
   endtask

   task automatic drive(input logic [3:0] r, input logic [3:0] c, input logic e, input int n);
      row = r; col = c; en = e;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int pulse_at;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("rst_digit_new", digit_new, 4'h0);
      chk("rst_digit_old", digit_old, 4'h0);
      chk("rst_key_valid", key_valid, 1'b0);
      chk("rst_key_held", key_held, 1'b0);
      reset = 1'b1;

      // Key 2: single pulse D+1 cycles after first hit
      row = 4'b0001; col = 4'b0010; en = 1'b1;
      pulse_at = -1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (key_valid && pulse_at < 0) pulse_at = i;
      end
      chk("s1_pulse_cycle", pulse_at, D + 1);
      chk("s1_pulses", pulses, 1);
      chk("s1_new", digit_new, 4'h2);
      chk("s1_old", digit_old, 4'h0);
      chk("s1_held", key_held, 1'b1);
      drive(4'd0, 4'd0, 1'b0, 6);

      // Key 5 then key C
      pulses = 0;
      drive(4'b0010, 4'b0010, 1'b1, 12);
      drive(4'd0, 4'd0, 1'b0, 6);
      drive(4'b0100, 4'b1000, 1'b1, 12);
      drive(4'd0, 4'd0, 1'b0, 6);
      chk("s2_pulses", pulses, 2);
      chk("s2_new", digit_new, 4'hC);
      chk("s2_old", digit_old, 4'h5);

      // Short presses of 7 abort
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         drive(4'b0100, 4'b0001, 1'b1, 5);
         drive(4'd0, 4'd0, 1'b0, 3);
      end
      chk("s3_pulses", pulses, 0);
      chk("s3_new", digit_new, 4'hC);
      chk("s3_held", key_held, 1'b0);

      // Key 9 with release bounce
      pulses = 0;
      drive(4'b0100, 4'b0100, 1'b1, 12);
      drive(4'd0, 4'd0, 1'b0, 2);
      drive(4'b0100, 4'b0100, 1'b1, 10);
      drive(4'd0, 4'd0, 1'b0, 6);
      chk("s4_pulses", pulses, 1);
      chk("s4_new", digit_new, 4'h9);
      chk("s4_old", digit_old, 4'hC);

      // Two columns at once is not a hit
      pulses = 0;
      drive(4'b0001, 4'b0110, 1'b1, 20);
      chk("s5_pulses", pulses, 0);
      chk("s5_held", key_held, 1'b0);
      drive(4'd0, 4'd0, 1'b0, 2);

      // Reset while D is held, then re-debounce with key still down
      drive(4'b1000, 4'b1000, 1'b1, 12);
      chk("s6_new_pre", digit_new, 4'hD);
      reset = 1'b0;
      #1;
      chk("s6_rst_new", digit_new, 4'h0);
      chk("s6_rst_old", digit_old, 4'h0);
      chk("s6_rst_valid", key_valid, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      pulses = 0;
      drive(4'b1000, 4'b1000, 1'b1, 12);
      chk("s6_pulses", pulses, 1);
      chk("s6_new", digit_new, 4'hD);
      chk("s6_old", digit_old, 4'h0);
      drive(4'd0, 4'd0, 1'b0, 6);

      // Randomized segments against the model
      for (int s = 0; s < 40; s++) begin
         int kind, len;
         logic [3:0] r, c;
         kind = $urandom_range(0, 3);
         len  = $urandom_range(1, 14);
         r    = 4'(1 << $urandom_range(0, 3));
         c    = 4'(1 << $urandom_range(0, 3));
         case (kind)
            0: drive(r, c, 1'b1, len);
            1: drive(4'd0, 4'd0, 1'b0, len);
            2: begin
               row = r; col = c;
               for (int i = 0; i < len; i++) begin
                  en = 1'($urandom_range(0, 1));
                  step();
               end
            end
            default: drive(r, 4'($urandom_range(0, 15)), 1'b1, len);
         endcase
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
